// File: rtl/sph_acc_pkg.sv
// Shared types and constants for the sphere-surface accumulator sequencer.
package sph_acc_pkg;
  localparam int DIN_W             = 26;
  localparam int ACC_W             = 32;
  localparam int INIT_FLUSH_CYCLES = 3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ACCUM,
    LATCH,
    CLEAR,
    WAIT_OUT
  } state_t;
endpackage

// File: rtl/sph_acc_seq.sv
// Frames a valid/ready sample stream into fixed-length accumulator windows and
// captures each window sum. Optional idle timeout: define SPH_ACC_TIMEOUT_EN.
module sph_acc_seq
  import sph_acc_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int TO_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIN_W-1:0] s_data,
  output logic             acc_en,
  output logic [DIN_W-1:0] acc_din,
  input  logic [ACC_W-1:0] acc_dout,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [ACC_W-1:0] r_data,
  output logic             r_err
);

  state_t           state, state_nx;
  logic [1:0]       init_cnt;
  logic [LEN_W-1:0] remaining;
  logic             zero_win;
  logic             err_pend;
  logic             hs;
  logic             hold_free;
  logic             capture;
  logic             timeout;
  logic             en_c;
  logic             ready_c;
  logic [DIN_W-1:0] din_c;

  assign hs        = (state == ACCUM) && s_valid;
  assign hold_free = !r_valid || r_ready;
  assign capture   = ((state == CLEAR) || (state == WAIT_OUT)) && hold_free;

`ifdef SPH_ACC_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst)                              idle_cnt <= '0;
    else if (state != ACCUM || s_valid)   idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + TO_W'(1);
  end

  assign timeout = (state == ACCUM) && !s_valid && (idle_cnt == TO_W'(TO_CYCLES - 1));
`else
  localparam int unused_to_cycles = TO_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    en_c     = 1'b0;
    ready_c  = 1'b0;
    din_c    = '0;
    case (state)
      INIT: begin
        // cycle 0 drives en high so the accumulator's read flag is defined
        en_c = (init_cnt == 2'd0);
        if (init_cnt == 2'(INIT_FLUSH_CYCLES - 1)) state_nx = IDLE;
      end
      IDLE: begin
        if (start) state_nx = (cfg_len != '0) ? ACCUM : CLEAR;
      end
      ACCUM: begin
        // en stays high all window; idle cycles feed zero instead of dropping en
        en_c    = 1'b1;
        ready_c = 1'b1;
        din_c   = s_valid ? s_data : '0;
        if ((hs && remaining == LEN_W'(1)) || timeout) state_nx = LATCH;
      end
      LATCH: state_nx = CLEAR;
      CLEAR, WAIT_OUT: state_nx = hold_free ? IDLE : WAIT_OUT;
      default: state_nx = INIT;
    endcase
  end

  // Gate with rst so nothing reaches the accumulator while reset is held.
  assign acc_en  = en_c & ~rst;
  assign acc_din = rst ? '0 : din_c;
  assign s_ready = ready_c & ~rst;
  assign busy    = (state != IDLE) | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      remaining <= '0;
      zero_win  <= 1'b0;
      err_pend  <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) init_cnt <= init_cnt + 2'd1;

      if (state == IDLE && start) begin
        remaining <= cfg_len;
        zero_win  <= (cfg_len == '0);
        err_pend  <= 1'b0;
      end else if (hs) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (timeout) err_pend <= 1'b1;

      // capture wins over consume, so r_valid stays high with fresh data
      if (capture) begin
        r_valid <= 1'b1;
        r_data  <= zero_win ? '0 : acc_dout;
        r_err   <= err_pend;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sph_acc_seq.sv
// Directed bench for sph_acc_seq with a behavioural accumulator model attached.
module tb_sph_acc_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        busy;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [25:0] s_data = '0;
  logic        acc_en;
  logic [25:0] acc_din;
  logic [31:0] acc_dout;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [31:0] r_data;
  logic        r_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sph_acc_seq #(.LEN_W(16), .TO_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .acc_en(acc_en), .acc_din(acc_din), .acc_dout(acc_dout),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err)
  );

  // Accumulator: sums while en; first en-low edge latches dout, next clears sum.
  logic [31:0] m_sum  = 32'hDEADBEEF;
  logic [31:0] m_dout = 32'h0BADF00D;
  logic        m_en_d = 1'b0;
  always @(posedge clk) begin
    if (acc_en) begin
      m_sum  <= m_sum + {{6{acc_din[25]}}, acc_din};
      m_en_d <= 1'b1;
    end else begin
      if (m_en_d) m_dout <= m_sum;
      else        m_sum  <= '0;
      m_en_d <= 1'b0;
    end
  end
  assign acc_dout = m_dout;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++; if (acc_en !== 1'b0) begin bad++; $display("FAIL rst_acc_en got=%b exp=0", acc_en); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
    total++; if ({r_valid, r_err, s_ready} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {r_valid, r_err, s_ready}); end
    total++; if (r_data !== 32'd0) begin bad++; $display("FAIL rst_r_data got=%h exp=0", r_data); end
    rst = 1'b0; #1;
    total++; if ({acc_en, acc_din} !== {1'b1, 26'd0}) begin bad++; $display("FAIL flush0 got en=%b din=%h exp en=1 din=0", acc_en, acc_din); end
    tick();
    total++; if ({acc_en, busy} !== 2'b01) begin bad++; $display("FAIL flush1 got en=%b busy=%b exp en=0 busy=1", acc_en, busy); end
    tick();
    total++; if ({acc_en, busy} !== 2'b01) begin bad++; $display("FAIL flush2 got en=%b busy=%b exp en=0 busy=1", acc_en, busy); end
    tick();
    total++; if ({acc_en, busy} !== 2'b00) begin bad++; $display("FAIL idle got en=%b busy=%b exp 0 0", acc_en, busy); end
  endtask

  task automatic test_basic();
    int vals[4] = '{10, -3, 7, 100};
    start = 1'b1; cfg_len = 16'd4; tick(); start = 1'b0;
    total++; if ({s_ready, busy} !== 2'b11) begin bad++; $display("FAIL basic_accum got ready=%b busy=%b exp 1 1", s_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 26'(vals[i]); #1;
      total++; if ({acc_en, acc_din} !== {1'b1, 26'(vals[i])}) begin bad++; $display("FAIL basic_din%0d got en=%b din=%h exp en=1 din=%h", i, acc_en, acc_din, 26'(vals[i])); end
      tick();
    end
    s_valid = 1'b0; #1;
    total++; if ({acc_en, r_valid} !== 2'b00) begin bad++; $display("FAIL basic_latch got en=%b rv=%b exp 0 0", acc_en, r_valid); end
    tick();
    total++; if ({acc_en, r_valid} !== 2'b00) begin bad++; $display("FAIL basic_clear got en=%b rv=%b exp 0 0", acc_en, r_valid); end
    tick();
    total++; if ({r_valid, busy, r_err} !== 3'b100) begin bad++; $display("FAIL basic_rv got rv=%b busy=%b err=%b exp 1 0 0", r_valid, busy, r_err); end
    total++; if (r_data !== 32'd114) begin bad++; $display("FAIL basic_sum got=%0d exp=114", r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got rv=%b exp 0", r_valid); end
  endtask

  task automatic test_gaps();
    logic vpat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    start = 1'b1; cfg_len = 16'd3; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = vpat[i]; s_data = 26'd5; #1;
      total++; if ({acc_en, acc_din} !== {1'b1, vpat[i] ? 26'd5 : 26'd0}) begin bad++; $display("FAIL gaps_cyc%0d got en=%b din=%h", i, acc_en, acc_din); end
      tick();
    end
    s_valid = 1'b0; tick(); tick();
    total++; if ({r_valid, r_data} !== {1'b1, 32'd15}) begin bad++; $display("FAIL gaps_sum got rv=%b data=%0d exp rv=1 data=15", r_valid, r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; cfg_len = 16'd2; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 26'd1; tick();
    s_data = 26'd2; tick();
    s_valid = 1'b0; tick(); tick();
    total++; if ({r_valid, r_data} !== {1'b1, 32'd3}) begin bad++; $display("FAIL b2b_first got rv=%b data=%h exp rv=1 data=3", r_valid, r_data); end
    start = 1'b1; cfg_len = 16'd2; tick(); start = 1'b0;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_turnaround got ready=%b exp 1", s_ready); end
    s_valid = 1'b1; s_data = 26'(-8); tick(); tick();
    s_valid = 1'b0; tick(); tick();
    for (int i = 0; i < 2; i++) begin
      total++; if ({busy, acc_en, r_valid, r_data} !== {3'b101, 32'd3}) begin bad++; $display("FAIL b2b_wait%0d got busy=%b en=%b rv=%b data=%h", i, busy, acc_en, r_valid, r_data); end
      tick();
    end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
    total++; if ({r_valid, busy, r_data} !== {2'b10, 32'hFFFFFFF0}) begin bad++; $display("FAIL b2b_second got rv=%b busy=%b data=%h exp rv=1 busy=0 data=fffffff0", r_valid, busy, r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL b2b_consume got rv=%b exp 0", r_valid); end
  endtask

  task automatic test_zero_len();
    start = 1'b1; cfg_len = 16'd0; #1;
    total++; if (acc_en !== 1'b0) begin bad++; $display("FAIL zero_idle_en got=%b exp 0", acc_en); end
    tick(); start = 1'b0;
    total++; if ({acc_en, busy} !== 2'b01) begin bad++; $display("FAIL zero_clear got en=%b busy=%b exp 0 1", acc_en, busy); end
    tick();
    total++; if ({r_valid, acc_en, r_data} !== {2'b10, 32'd0}) begin bad++; $display("FAIL zero_result got rv=%b en=%b data=%h exp rv=1 en=0 data=0", r_valid, acc_en, r_data); end
  endtask

  task automatic test_rst_mid();
    start = 1'b1; cfg_len = 16'd5; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 26'd11; tick();
    s_data = 26'd22; tick();
    s_valid = 1'b0; rst = 1'b1; tick();
    total++; if ({r_valid, acc_en, busy, s_ready} !== 4'b0010) begin bad++; $display("FAIL rstmid_state got rv=%b en=%b busy=%b rdy=%b exp 0 0 1 0", r_valid, acc_en, busy, s_ready); end
    rst = 1'b0; #1;
    total++; if (acc_en !== 1'b1) begin bad++; $display("FAIL rstmid_flush0 got=%b exp 1", acc_en); end
    tick(); tick(); tick();
    total++; if ({busy, acc_en} !== 2'b00) begin bad++; $display("FAIL rstmid_idle got busy=%b en=%b exp 0 0", busy, acc_en); end
    start = 1'b1; cfg_len = 16'd1; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 26'd7; tick();
    s_valid = 1'b0; tick(); tick();
    total++; if ({r_valid, r_data} !== {1'b1, 32'd7}) begin bad++; $display("FAIL rstmid_next got rv=%b data=%0d exp rv=1 data=7", r_valid, r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
  endtask

`ifdef SPH_ACC_TIMEOUT_EN
  task automatic test_timeout();
    start = 1'b1; cfg_len = 16'd5; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 26'd9; tick(); tick();
    s_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL to_early got rv=%b exp 0", r_valid); end
    tick();
    total++; if ({r_valid, r_err, r_data} !== {2'b11, 32'd18}) begin bad++; $display("FAIL to_result got rv=%b err=%b data=%0d exp 1 1 18", r_valid, r_err, r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
    total++; if ({r_valid, r_err} !== 2'b00) begin bad++; $display("FAIL to_consume got rv=%b err=%b exp 0 0", r_valid, r_err); end
  endtask
`else
  task automatic test_no_timeout();
    start = 1'b1; cfg_len = 16'd5; tick(); start = 1'b0;
    s_valid = 1'b1; s_data = 26'd9; tick(); tick();
    s_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++; if ({r_valid, s_ready, acc_en} !== 3'b011) begin bad++; $display("FAIL noto_wait got rv=%b rdy=%b en=%b exp 0 1 1", r_valid, s_ready, acc_en); end
    s_valid = 1'b1; s_data = 26'd1; tick(); tick(); tick();
    s_valid = 1'b0; tick(); tick();
    total++; if ({r_valid, r_err, r_data} !== {2'b10, 32'd21}) begin bad++; $display("FAIL noto_result got rv=%b err=%b data=%0d exp 1 0 21", r_valid, r_err, r_data); end
    r_ready = 1'b1; tick(); r_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_zero_len();
    test_rst_mid();
`ifdef SPH_ACC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
